rgb2hsv_pipe: RTL and testbench



---
 rtl/rgb2hsv_pipe_if.sv | 40 ++++
 rtl/rgb2hsv_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_rgb2hsv_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rgb2hsv_pipe_if.sv
// Pixel stream bundle for rgb2hsv_pipe: RGB pixel in, HSV pixel out, valid/user alongside.
// Threshold controls and out_mask exist only when RGB2HSV_THRESH_EN is defined.
interface rgb2hsv_pipe_if #(
    parameter int DW     = 8,
    parameter int USER_W = 3
);
    logic              in_valid;
    logic [USER_W-1:0] in_user;
    logic [3*DW-1:0]   in_rgb;
    logic              out_valid;
    logic [USER_W-1:0] out_user;
    logic [8:0]        out_hue;
    logic [DW-1:0]     out_sat;
    logic [DW-1:0]     out_val;
`ifdef RGB2HSV_THRESH_EN
    logic [8:0]        th_h_lo;
    logic [8:0]        th_h_hi;
    logic [DW-1:0]     th_s_min;
    logic [DW-1:0]     th_v_min;
    logic              out_mask;

    modport master (
        output in_valid, in_user, in_rgb, th_h_lo, th_h_hi, th_s_min, th_v_min,
        input  out_valid, out_user, out_hue, out_sat, out_val, out_mask
    );
    modport slave (
        input  in_valid, in_user, in_rgb, th_h_lo, th_h_hi, th_s_min, th_v_min,
        output out_valid, out_user, out_hue, out_sat, out_val, out_mask
    );
`else
    modport master (
        output in_valid, in_user, in_rgb,
        input  out_valid, out_user, out_hue, out_sat, out_val
    );
    modport slave (
        input  in_valid, in_user, in_rgb,
        output out_valid, out_user, out_hue, out_sat, out_val
    );
`endif
endinterface

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB->HSV converter, latency 2*DW+3, bit-serial restoring dividers.
// Define RGB2HSV_THRESH_EN to add the colour-threshold mask output.
module rgb2hsv_pipe #(
    parameter int DW       = 8,
    parameter int USER_W   = 3,
    parameter int HUE_FULL = 0
) (
    input  logic          pclk,
    input  logic          rst_n,
    rgb2hsv_pipe_if.slave px
);
    localparam int unsigned NS = 2 * DW;     // divider stages, one quotient bit each
    localparam int unsigned QW = 2 * DW;
    localparam int unsigned PW = 2 * DW + 6; // holds 60*x even when DW < 6

    // S1: register channels with their max/min
    logic [DW-1:0]     in_r, in_g, in_b, in_max, in_min;
    logic [DW-1:0]     s1_r, s1_g, s1_b, s1_max, s1_min;
    logic              s1_valid;
    logic [USER_W-1:0] s1_user;

    always_comb begin
        in_r   = px.in_rgb[3*DW-1:2*DW];
        in_g   = px.in_rgb[2*DW-1:DW];
        in_b   = px.in_rgb[DW-1:0];
        in_max = in_r;
        if (in_g > in_max) in_max = in_g;
        if (in_b > in_max) in_max = in_b;
        in_min = in_r;
        if (in_g < in_min) in_min = in_g;
        if (in_b < in_min) in_min = in_b;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_max   <= '0;
            s1_min   <= '0;
            s1_valid <= 1'b0;
            s1_user  <= '0;
        end else begin
            s1_r     <= in_r;
            s1_g     <= in_g;
            s1_b     <= in_b;
            s1_max   <= in_max;
            s1_min   <= in_min;
            s1_valid <= px.in_valid;
            s1_user  <= px.in_user;
        end
    end

    // S2: hue sector select (R, then G, then B on ties), dividends and divisors
    logic [DW-1:0] delta, diff, h_dsr, s_dsr;
    logic [8:0]    base;
    logic          neg;
    logic [PW-1:0] h_prod, s_prod;

    always_comb begin
        delta = s1_max - s1_min;
        neg   = 1'b0;
        diff  = '0;
        base  = 9'd0;
        if (s1_max == s1_r) begin
            neg  = s1_g < s1_b;
            diff = neg ? s1_b - s1_g : s1_g - s1_b;
            base = neg ? 9'd360 : 9'd0;
        end else if (s1_max == s1_g) begin
            neg  = s1_b < s1_r;
            diff = neg ? s1_r - s1_b : s1_b - s1_r;
            base = 9'd120;
        end else begin
            neg  = s1_r < s1_g;
            diff = neg ? s1_g - s1_r : s1_r - s1_g;
            base = 9'd240;
        end
        h_prod = PW'(diff) * PW'(60);
        s_prod = PW'({DW{1'b1}}) * PW'(delta);
        h_dsr  = delta;
        s_dsr  = s1_max;
        if (delta == '0) begin
            h_prod = '0;
            s_prod = '0;
            h_dsr  = DW'(1);
            s_dsr  = DW'(1);
            base   = 9'd0;
            neg    = 1'b0;
        end
    end

    // Divider lanes: stage k holds partial remainder, unconsumed dividend bits, divisor.
    logic [DW-1:0]     h_rem [0:NS-1];
    logic [QW-1:0]     h_dvd [0:NS-1];
    logic [DW-1:0]     h_div [0:NS-1];
    logic [DW-1:0]     s_rem [0:NS-1];
    logic [QW-1:0]     s_dvd [0:NS-1];
    logic [DW-1:0]     s_div [0:NS-1];
    logic [6:0]        h_quo [0:NS];
    logic [DW-1:0]     s_quo [0:NS];
    logic              p_valid [0:NS];
    logic [USER_W-1:0] p_user  [0:NS];
    logic [8:0]        p_base  [0:NS];
    logic              p_neg   [0:NS];
    logic [DW-1:0]     p_val   [0:NS];
    logic [DW:0]       h_st [0:NS-1];
    logic [DW:0]       s_st [0:NS-1];

    // Returns {quotient bit, next remainder}; remainder stays below the divisor.
    function automatic logic [DW:0] div_step(input logic [DW-1:0] rem, input logic nb,
                                             input logic [DW-1:0] dsr);
        logic [DW:0]   trial;
        logic [DW-1:0] sub;
        trial = {rem, nb};
        sub   = DW'(trial - {1'b0, dsr});
        if (trial >= {1'b0, dsr}) return {1'b1, sub};
        return {1'b0, trial[DW-1:0]};
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NS; k++) begin
            h_st[k] = div_step(h_rem[k], h_dvd[k][QW-1], h_div[k]);
            s_st[k] = div_step(s_rem[k], s_dvd[k][QW-1], s_div[k]);
        end
    end

    // Bits of the product above QW preload the remainder; their quotient part is known to be zero.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NS; k++) begin
                h_rem[k] <= '0;
                h_dvd[k] <= '0;
                h_div[k] <= '0;
                s_rem[k] <= '0;
                s_dvd[k] <= '0;
                s_div[k] <= '0;
            end
            for (int unsigned k = 0; k <= NS; k++) begin
                h_quo[k]   <= '0;
                s_quo[k]   <= '0;
                p_valid[k] <= 1'b0;
                p_user[k]  <= '0;
                p_base[k]  <= '0;
                p_neg[k]   <= 1'b0;
                p_val[k]   <= '0;
            end
        end else begin
            h_rem[0]   <= DW'(h_prod >> QW);
            h_dvd[0]   <= h_prod[QW-1:0];
            h_div[0]   <= h_dsr;
            s_rem[0]   <= DW'(s_prod >> QW);
            s_dvd[0]   <= s_prod[QW-1:0];
            s_div[0]   <= s_dsr;
            h_quo[0]   <= '0;
            s_quo[0]   <= '0;
            p_valid[0] <= s1_valid;
            p_user[0]  <= s1_user;
            p_base[0]  <= base;
            p_neg[0]   <= neg;
            p_val[0]   <= s1_max;
            for (int unsigned k = 0; k < NS; k++) begin
                if (k + 1 < NS) begin
                    h_rem[k+1] <= h_st[k][DW-1:0];
                    h_dvd[k+1] <= {h_dvd[k][QW-2:0], 1'b0};
                    h_div[k+1] <= h_div[k];
                    s_rem[k+1] <= s_st[k][DW-1:0];
                    s_dvd[k+1] <= {s_dvd[k][QW-2:0], 1'b0};
                    s_div[k+1] <= s_div[k];
                end
                h_quo[k+1]   <= {h_quo[k][5:0], h_st[k][DW]};
                s_quo[k+1]   <= {s_quo[k][DW-2:0], s_st[k][DW]};
                p_valid[k+1] <= p_valid[k];
                p_user[k+1]  <= p_user[k];
                p_base[k+1]  <= p_base[k];
                p_neg[k+1]   <= p_neg[k];
                p_val[k+1]   <= p_val[k];
            end
        end
    end

    // Final stage: combine base and quotient, wrap 360 to 0, scale
    logic [9:0] q10, deg;
    logic [8:0] hue9;

    always_comb begin
        q10 = {3'b000, h_quo[NS]};
        deg = p_neg[NS] ? {1'b0, p_base[NS]} - q10 : {1'b0, p_base[NS]} + q10;
        if (deg == 10'd360) deg = '0;
        hue9 = (HUE_FULL != 0) ? deg[8:0] : deg[9:1];
    end

`ifdef RGB2HSV_THRESH_EN
    logic hue_in, mask_d;

    always_comb begin
        if (px.th_h_lo <= px.th_h_hi)
            hue_in = (hue9 >= px.th_h_lo) && (hue9 <= px.th_h_hi);
        else
            hue_in = (hue9 >= px.th_h_lo) || (hue9 <= px.th_h_hi);
        mask_d = p_valid[NS] && hue_in && (s_quo[NS] >= px.th_s_min) &&
                 (p_val[NS] >= px.th_v_min);
    end
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            px.out_valid <= 1'b0;
            px.out_user  <= '0;
            px.out_hue   <= '0;
            px.out_sat   <= '0;
            px.out_val   <= '0;
`ifdef RGB2HSV_THRESH_EN
            px.out_mask  <= 1'b0;
`endif
        end else begin
            px.out_valid <= p_valid[NS];
            px.out_user  <= p_user[NS];
            px.out_hue   <= hue9;
            px.out_sat   <= s_quo[NS];
            px.out_val   <= p_val[NS];
`ifdef RGB2HSV_THRESH_EN
            px.out_mask  <= mask_d;
`endif
        end
    end
endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Directed bench for rgb2hsv_pipe: two instances (HUE_FULL 0 and 1) fed identical pixels,
// outputs compared every cycle against hand-computed values delayed by the fixed latency.
module tb_rgb2hsv_pipe;
    localparam int DW     = 8;
    localparam int USER_W = 3;
    localparam int LAT    = 2 * DW + 3;

    typedef struct {
        int r; int g; int b;
        int h0; int h1; int s; int v; int m;
    } px_t;

    logic pclk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   trk_from = 32'h3fff_ffff;

    px_t         tbl [0:17];
    bit          hist_v [0:1023];
    logic [2:0]  hist_u [0:1023];
    px_t         hist_p [0:1023];
    px_t         mp;
    int          mk;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    rgb2hsv_pipe_if #(.DW(DW), .USER_W(USER_W)) if0 ();
    rgb2hsv_pipe_if #(.DW(DW), .USER_W(USER_W)) if1 ();

    rgb2hsv_pipe #(.DW(DW), .USER_W(USER_W), .HUE_FULL(0)) dut0 (
        .pclk(pclk), .rst_n(rst_n), .px(if0)
    );
    rgb2hsv_pipe #(.DW(DW), .USER_W(USER_W), .HUE_FULL(1)) dut1 (
        .pclk(pclk), .rst_n(rst_n), .px(if1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Drive one cycle of input and remember what the outputs must show LAT cycles later.
    task automatic step(input bit v, input int u, input int idx);
        px_t p;
        if (idx >= 0) p = tbl[idx];
        else p = '{default: 0};
        if0.in_valid = v;
        if1.in_valid = v;
        if0.in_user  = 3'(u);
        if1.in_user  = 3'(u);
        if0.in_rgb   = {DW'(p.r), DW'(p.g), DW'(p.b)};
        if1.in_rgb   = {DW'(p.r), DW'(p.g), DW'(p.b)};
        hist_v[cyc]  = v;
        hist_u[cyc]  = 3'(u);
        hist_p[cyc]  = p;
        @(posedge pclk);
        #1;
    endtask

    always @(negedge pclk) begin
        if (!rst_n) begin
            check("rst_valid", if0.out_valid, 0);
            check("rst_user", if0.out_user, 0);
            check("rst_hue", if0.out_hue, 0);
            check("rst_sat", if0.out_sat, 0);
            check("rst_val", if0.out_val, 0);
            check("rst_valid_full", if1.out_valid, 0);
`ifdef RGB2HSV_THRESH_EN
            check("rst_mask", if0.out_mask, 0);
`endif
        end else begin
            mk = cyc - LAT;
            if (mk >= trk_from) begin
                check("valid", if0.out_valid, hist_v[mk]);
                check("user", if0.out_user, hist_u[mk]);
                check("valid_full", if1.out_valid, hist_v[mk]);
                if (hist_v[mk]) begin
                    mp = hist_p[mk];
                    check("hue", if0.out_hue, mp.h0);
                    check("hue_full", if1.out_hue, mp.h1);
                    check("sat", if0.out_sat, mp.s);
                    check("val", if0.out_val, mp.v);
`ifdef RGB2HSV_THRESH_EN
                    check("mask", if0.out_mask, mp.m);
                end else begin
                    check("mask_bubble", if0.out_mask, 0);
`endif
                end
            end else begin
                check("stale_valid", if0.out_valid, 0);
                check("stale_user", if0.out_user, 0);
            end
        end
    end

    initial begin
        //             r    g    b   h0   h1    s    v  m
        tbl[0]  = '{255,   0,   0,   0,   0, 255, 255, 1};
        tbl[1]  = '{  0, 255,   0,  60, 120, 255, 255, 0};
        tbl[2]  = '{  0,   0, 255, 120, 240, 255, 255, 0};
        tbl[3]  = '{128, 128, 128,   0,   0,   0, 128, 0};
        tbl[4]  = '{255,   0, 128, 165, 330, 255, 255, 0};
        tbl[5]  = '{255,   0,   1,   0,   0, 255, 255, 1};
        tbl[6]  = '{200, 100,  50,  10,  20, 191, 200, 1};
        tbl[7]  = '{ 50, 200, 100,  70, 140, 191, 200, 0};
        tbl[8]  = '{100,  50, 200, 130, 260, 191, 200, 0};
        tbl[9]  = '{ 10,  20,  30, 105, 210, 170,  30, 0};
        tbl[10] = '{  0,   0,   0,   0,   0,   0,   0, 0};
        tbl[11] = '{255, 255,   0,  30,  60, 255, 255, 0};
        tbl[12] = '{  0, 255, 255,  90, 180, 255, 255, 0};
        tbl[13] = '{ 30,  10,  20, 165, 330, 170,  30, 0};
        tbl[14] = '{200,  50, 100, 170, 340, 191, 200, 1};
        tbl[15] = '{  1,   0,   0,   0,   0, 255,   1, 0};
        tbl[16] = '{100, 200,  50,  50, 100, 191, 200, 0};
        tbl[17] = '{ 50, 100, 200, 110, 220, 191, 200, 0};

        rst_n = 1'b0;
`ifdef RGB2HSV_THRESH_EN
        if0.th_h_lo = 9'd170;  if1.th_h_lo = 9'd170;
        if0.th_h_hi = 9'd10;   if1.th_h_hi = 9'd10;
        if0.th_s_min = 8'd100; if1.th_s_min = 8'd100;
        if0.th_v_min = 8'd100; if1.th_v_min = 8'd100;
`endif
        for (int i = 0; i < 5; i++) step(1'b0, 0, -1);
        rst_n = 1'b1;
        trk_from = cyc;

        for (int i = 0; i < 25; i++) step(1'b0, 0, -1);
        check("idle_hue", if0.out_hue, 0);
        check("idle_sat", if0.out_sat, 0);
        check("idle_val", if0.out_val, 0);

        step(1'b1, 5, 0);
        for (int i = 0; i < 22; i++) step(1'b0, 0, -1);

        for (int i = 0; i < 18; i++) step(1'b1, i, i);
        for (int i = 0; i < 21; i++) step(1'b0, 0, -1);

        for (int i = 0; i < 25; i++) step((i % 2) == 0, i, i % 18);
        check("pre_rst_valid", if0.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", if0.out_valid, 0);
        check("async_rst_user", if0.out_user, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 7, i);
        rst_n = 1'b1;
        trk_from = cyc;
        for (int i = 0; i < 10; i++) step((i % 2) == 1, i + 2, (i + 5) % 18);
        for (int i = 0; i < 25; i++) step(1'b0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
